vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator for the 640x480@60 Hz display path. It runs on the pixel clock and produces the beam coordinates (DrawX, DrawY), the display-enable `blank`, and the active-low sync pulses that every sprite/background drawing stage consumes. It also produces per-frame strobes, a frame counter and a slow animation-frame index that sprite stages use to select sub-images, such as the spinning coin frames. All outputs are registered and mutually aligned, so downstream stages see one consistent beam position per cycle.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- ANIM_DIV, 8, frames per animation step (≥1)
- ANIM_W, 3, width of anim_frame
- vga_clk  in  1  pixel clock (25 MHz), single clock domain, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800)
- DrawY  out  10  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  display enable: 1 = visible pixel, 0 = blanking (downstream draws only when 1)
- frame_start  out  1  one-cycle strobe at (DrawX,DrawY) = (0,0)
- vblank_start  out  1  one-cycle strobe at (0,V_VIS); game-state update point
- frame_count  out  16  frames started since reset, wraps 65535→0
- anim_frame  out  ANIM_W  animation index, steps every ANIM_DIV frames, wraps 2^ANIM_W−1→0

## Operation
- The horizontal counter increments every cycle and wraps at H_TOTAL−1→0. When it wraps, the vertical counter increments, and the vertical counter wraps at V_TOTAL−1→0.
- hs = 0 iff H_VIS+H_FP ≤ DrawX < H_VIS+H_FP+H_SYNC (656..751 by default). vs = 0 iff V_VIS+V_FP ≤ DrawY < V_VIS+V_FP+V_SYNC (490..491).
- blank = 1 iff DrawX < H_VIS and DrawY < V_VIS.
- frame_start is 1 exactly in the cycle DrawX=0, DrawY=0. vblank_start is 1 exactly in the cycle DrawX=0, DrawY=V_VIS.
- frame_count increments in the cycle frame_start is asserted, so it reads 1 during the first frame after reset. The frame_count value is visible starting the same cycle as the strobe.
- A frame divider counts frame_start pulses 0..ANIM_DIV−1. When it wraps back to 0, anim_frame increments. With ANIM_DIV=1, anim_frame advances on every frame_start.
- All outputs come from registers. They are computed from next-state counter values so that hs/vs/blank/strobes describe the same position as DrawX/DrawY in the same cycle, with no skew between them.

## Timing
- Reset (async assert, sync effect on release) puts the generator at the last pixel of a frame. Reset values:
  - DrawX=H_TOTAL−1 (799), DrawY=V_TOTAL−1 (524)
  - hs=1, vs=1, blank=0
  - frame_start=0, vblank_start=0
  - frame_count=0, anim_frame=0, frame divider=0
- The first rising edge after reset_n rises gives DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1.
- If reset asserts mid-frame, all outputs take their reset values immediately (asynchronously). No partial sync pulse may persist.
- Line period is 800 cycles and frame period is 420000 cycles. hs is low for exactly H_SYNC consecutive cycles per line. vs is low for exactly V_SYNC×H_TOTAL cycles per frame, changing only at DrawX=0.
- frame_count wraps 65535→0 with no extra strobe behaviour.
- A downstream sprite stage using DrawX for a negedge ROM read and a posedge pixel register adds 1 cycle of pixel latency. That latency is absorbed by the porch and does not need compensation here.

## Test plan
- Reset release → next cycle DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1, hs=vs=1. During reset, outputs are 799/524/1/1/0.
- One full line from (0,0) → blank falls exactly at DrawX=640. hs is low for DrawX 656..751 (96 cycles). At DrawX=799 the next edge gives DrawX=0, DrawY=1.
- One full frame → vs is low only for DrawY 490..491. vblank_start fires once, at (0,480). frame_start fires once per 420000 cycles. blank=0 for all DrawY≥480.
- Run 17 frames with ANIM_DIV=8, ANIM_W=3 → anim_frame is 0 for frame_count 1..7, 1 for 8..15, and 2 from 16. Forcing 9 steps shows the wrap 7→0.
- Assert reset_n low mid-line at DrawX=300, DrawY=200 → outputs return to reset values asynchronously. After release, the sequence restarts at (0,0) with frame_count=1.
- Preload frame_count near its limit (or run a reduced-timing build with H_TOTAL=8, V_TOTAL=4) → verify the 65535→0 wrap and that strobes keep their one-cycle width with small parameters.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator for the 640x480@60 display path.
// Produces beam position, syncs, blank, frame strobes and animation index.
module vga_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ANIM_DIV = 8,
    parameter int ANIM_W   = 3
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    output logic [9:0]        DrawX,
    output logic [9:0]        DrawY,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic              frame_start,
    output logic              vblank_start,
    output logic [15:0]       frame_count,
    output logic [ANIM_W-1:0] anim_frame
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_VIS + H_FP;
    localparam int HS_END  = H_VIS + H_FP + H_SYNC;
    localparam int VS_BEG  = V_VIS + V_FP;
    localparam int VS_END  = V_VIS + V_FP + V_SYNC;
    localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [9:0]        h_q, h_d;
    logic [9:0]        v_q, v_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              blank_q, blank_d;
    logic              fs_q, fs_d;
    logic              vbs_q, vbs_d;
    logic [15:0]       fc_q, fc_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic              h_wrap;
    logic              div_wrap;

    // Advance the beam and derive every output from the next position
    // so all registered outputs describe the same pixel.
    always_comb begin
        h_wrap   = (h_q == 10'(H_TOTAL - 1));
        h_d      = h_wrap ? 10'd0 : h_q + 10'd1;
        v_d      = v_q;
        if (h_wrap) begin
            v_d = (v_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_q + 10'd1;
        end
        hs_d     = !((h_d >= 10'(HS_BEG)) && (h_d < 10'(HS_END)));
        vs_d     = !((v_d >= 10'(VS_BEG)) && (v_d < 10'(VS_END)));
        blank_d  = (h_d < 10'(H_VIS)) && (v_d < 10'(V_VIS));
        fs_d     = (h_d == 10'd0) && (v_d == 10'd0);
        vbs_d    = (h_d == 10'd0) && (v_d == 10'(V_VIS));
        div_wrap = (div_q == DIV_W'(ANIM_DIV - 1));
        fc_d     = fc_q;
        div_d    = div_q;
        anim_d   = anim_q;
        if (fs_d) begin
            fc_d  = fc_q + 16'd1;
            div_d = div_wrap ? '0 : div_q + DIV_W'(1);
            if (div_wrap) begin
                anim_d = anim_q + ANIM_W'(1);
            end
        end
    end

    // State and output registers; reset parks the beam on the last pixel.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= 10'(H_TOTAL - 1);
            v_q     <= 10'(V_TOTAL - 1);
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            vbs_q   <= 1'b0;
            fc_q    <= '0;
            div_q   <= '0;
            anim_q  <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
            vbs_q   <= vbs_d;
            fc_q    <= fc_d;
            div_q   <= div_d;
            anim_q  <= anim_d;
        end
    end

    assign DrawX        = h_q;
    assign DrawY        = v_q;
    assign hs           = hs_q;
    assign vs           = vs_q;
    assign blank        = blank_q;
    assign frame_start  = fs_q;
    assign vblank_start = vbs_q;
    assign frame_count  = fc_q;
    assign anim_frame   = anim_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster.
// Expected beam state is computed from elapsed cycles since reset.
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 6, HB = 4;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int AD = 8;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic        vbs;
        logic [15:0] fc;
        logic [2:0]  anim;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        hs, vs, blank, frame_start, vblank_start;
    logic [15:0] frame_count;
    logic [2:0]  anim_frame;

    exp_t q[$];
    exp_t last;
    int   t;
    int   n_cmp;
    int   n_bad;

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ANIM_DIV(AD), .ANIM_W(3)
    ) dut (
        .vga_clk(clk),
        .reset_n(reset_n),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .hs(hs),
        .vs(vs),
        .blank(blank),
        .frame_start(frame_start),
        .vblank_start(vblank_start),
        .frame_count(frame_count),
        .anim_frame(anim_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // t = number of active edges since reset was released (0 = in reset)
    function automatic exp_t model(input int tt);
        exp_t e;
        int n, pos, x, y, fr;
        if (tt == 0) begin
            e.x = 10'(HT - 1);
            e.y = 10'(VT - 1);
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.blank = 1'b0;
            e.fs = 1'b0;
            e.vbs = 1'b0;
            e.fc = 16'd0;
            e.anim = 3'd0;
            return e;
        end
        n   = tt - 1;
        pos = n % FR;
        x   = pos % HT;
        y   = pos / HT;
        fr  = n / FR + 1;
        e.x = 10'(x);
        e.y = 10'(y);
        e.hs = !(x >= HV + HF && x < HV + HF + HS);
        e.vs = !(y >= VV + VF && y < VV + VF + VS);
        e.blank = (x < HV) && (y < VV);
        e.fs = (x == 0) && (y == 0);
        e.vbs = (x == 0) && (y == VV);
        e.fc = 16'(fr % 65536);
        e.anim = 3'((fr / AD) % 8);
        return e;
    endfunction

    // one cycle: account for the edge, then drive reset and queue expectation
    task automatic step(input logic r);
        @(posedge clk);
        if (reset_n) t = t + 1;
        else t = 0;
        #2;
        reset_n = r;
        if (!r) t = 0;
        last = model(t);
        q.push_back(last);
    endtask

    task automatic run(input int n, input logic r);
        for (int i = 0; i < n; i++) step(r);
    endtask

    // monitor: pop and compare once per cycle, away from the active edge
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{DrawX, DrawY, hs, vs, blank, frame_start,
                      vblank_start, frame_count, anim_frame};
                n_cmp = n_cmp + 1;
                if (a !== e) begin
                    n_bad = n_bad + 1;
                    $display("FAIL beam t=%0d got x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b vb=%b fc=%0d an=%0d want x=%0d y=%0d hs=%b vs=%b bl=%b fs=%b vb=%b fc=%0d an=%0d",
                        t, a.x, a.y, a.hs, a.vs, a.blank, a.fs, a.vbs,
                        a.fc, a.anim, e.x, e.y, e.hs, e.vs, e.blank,
                        e.fs, e.vbs, e.fc, e.anim);
                end
            end
        end
    end

    initial begin
        int guard;
        n_cmp   = 0;
        n_bad   = 0;
        t       = 0;
        reset_n = 1'b0;
        run(3, 1'b0);
        run(17 * FR + 5, 1'b1);
        guard = 0;
        while (!(last.x == 10'd12 && last.y == 10'd5) && guard < FR + 2) begin
            step(1'b1);
            guard++;
        end
        if (guard >= FR + 2) begin
            n_bad = n_bad + 1;
            $display("FAIL midframe_seek got x=%0d y=%0d want 12/5",
                     last.x, last.y);
        end
        run(2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run($urandom_range(50, 1500), 1'b1);
            run($urandom_range(1, 3), 1'b0);
        end
        run(66 * FR, 1'b1);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
